// File: rtl/crossing_request_scheduler_if.sv
// Start/busy handshake between the request scheduler
// and the crossing light sequencer.
interface crossing_request_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int SEL_W = $clog2(N_REQ);

  logic             xing_start;
  logic             xing_busy;
  logic [SEL_W-1:0] xing_sel;

  modport master (
    output xing_start,
    output xing_sel,
    input  xing_busy
  );

  modport slave (
    input  xing_start,
    input  xing_sel,
    output xing_busy
  );
endinterface

// File: rtl/crossing_request_scheduler.sv
// Round-robin scheduler sharing one crossing sequencer among N_REQ buttons.
// Optional button debounce is built when DEBOUNCE_EN is defined.
module crossing_request_scheduler #(
  parameter int N_REQ        = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int ACK_TIMEOUT  = 16,
  parameter int MIN_GAP      = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     btn,
  crossing_request_scheduler_if.master xing,
  output logic [N_REQ-1:0]     pending,
  output logic                 ack_fault
);

  localparam int SEL_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(ACK_TIMEOUT) + 1;
  localparam int GAP_W = $clog2(MIN_GAP) + 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);
  localparam logic [SEL_W-1:0] RR_INIT  = SEL_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    RUN,
    HOLDOFF
  } state_t;

  state_t             state;
  logic               start_q;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   rr_last;
  logic [SEL_W-1:0]   winner;
  logic [TO_W-1:0]    to_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [N_REQ-1:0]   sync1;
  logic [N_REQ-1:0]   sync2;
  logic [N_REQ-1:0]   btn_c;
  logic [N_REQ-1:0]   btn_q;
  logic [N_REQ-1:0]   rise;
  logic [N_REQ-1:0]   pend_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      btn_q <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      btn_q <= btn_c;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0]  db_cnt [N_REQ];
  logic [N_REQ-1:0] db_lvl;

  // Level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_lvl <= '0;
      for (int i = 0; i < N_REQ; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_c = db_lvl;
`else
  assign btn_c = sync2;
`endif

  assign rise = btn_c & ~btn_q;

  // Scan downward so the nearest set bit after rr_last is kept.
  always_comb begin
    winner = rr_last;
    for (int k = N_REQ; k >= 1; k--) begin
      if (pending[(int'(rr_last) + k) % N_REQ])
        winner = SEL_W'((int'(rr_last) + k) % N_REQ);
    end
  end

  always_comb begin
    pend_n = pending | rise;
    if (state == START) pend_n[sel] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      sel       <= '0;
      rr_last   <= RR_INIT;
      pending   <= '0;
      ack_fault <= 1'b0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      pending <= pend_n;
      start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|pending) begin
            sel     <= winner;
            rr_last <= winner;
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (xing.xing_busy) begin
            state <= RUN;
          end else if (to_cnt == TO_LAST) begin
            ack_fault <= 1'b1;
            state     <= IDLE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!xing.xing_busy) begin
            gap_cnt <= '0;
            state   <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign xing.xing_start = start_q;
  assign xing.xing_sel   = sel;

endmodule

// File: tb/tb_crossing_request_scheduler.sv
// Directed bench for crossing_request_scheduler with a small
// sequencer model that answers each start with a busy window.
module tb_crossing_request_scheduler;

  localparam int NR = 4;
  localparam int DC = 4;
  localparam int AT = 16;
  localparam int MG = 20;
  localparam int BL = 20;
`ifdef DEBOUNCE_EN
  localparam int PRESS = DC + 3;
`else
  localparam int PRESS = 3;
`endif

  logic          clock;
  logic          reset;
  logic [NR-1:0] btn;
  logic [NR-1:0] pending;
  logic          ack_fault;

  logic model_en;
  logic model_busy;
  logic man_busy;
  int   busy_cnt;

  int tests;
  int fails;

  int cyc;
  int n_starts;
  int fall_cyc;
  logic prev_busy;
  int start_sel  [64];
  int start_cyc  [64];
  int start_fall [64];

  crossing_request_scheduler_if #(.N_REQ(NR)) xing ();

  assign xing.xing_busy = model_en ? model_busy : man_busy;

  crossing_request_scheduler #(
    .N_REQ(NR),
    .DEBOUNCE_CYC(DC),
    .ACK_TIMEOUT(AT),
    .MIN_GAP(MG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn(btn),
    .xing(xing),
    .pending(pending),
    .ack_fault(ack_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    cyc = 0;
    n_starts = 0;
    fall_cyc = 0;
    prev_busy = 1'b0;
    busy_cnt = 0;
    model_busy = 1'b0;
  end

  // Start/busy monitor: records every start and the last busy fall.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (prev_busy && !xing.xing_busy) fall_cyc = cyc;
    prev_busy = xing.xing_busy;
    if (xing.xing_start && n_starts < 64) begin
      start_sel[n_starts]  = int'(xing.xing_sel);
      start_cyc[n_starts]  = cyc;
      start_fall[n_starts] = fall_cyc;
      n_starts++;
    end
  end

  // Sequencer model: busy rises the cycle after start, lasts BL cycles.
  always @(posedge clock) begin
    #2;
    if (!model_en) busy_cnt = 0;
    else if (xing.xing_start) busy_cnt = BL;
    else if (busy_cnt > 0) busy_cnt--;
    model_busy = (busy_cnt > 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #3;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn = '0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic press(input logic [NR-1:0] b, input int n);
    btn = b;
    step(n);
    btn = '0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k;
    k = 0;
    while (n_starts < target && k < budget) begin
      step(1);
      k++;
    end
    check("start_count", n_starts, target);
  endtask

  function automatic logic gap_ok(input int idx);
    int d;
    d = start_cyc[idx] - start_fall[idx];
    return (d >= MG) && (d <= MG + 2);
  endfunction

  initial begin
    int n0;
    int wait_n;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    btn = '0;
    model_en = 1'b0;
    man_busy = 1'b0;

    // Reset state
    step(3);
    reset = 1'b0;
    check("rst_start", xing.xing_start, 0);
    check("rst_sel", xing.xing_sel, 0);
    check("rst_pending", pending, 0);
    check("rst_fault", ack_fault, 0);

    // Single held button gets exactly one crossing
    model_en = 1'b1;
    press(4'b0001, 10);
    check("t1_starts", n_starts, 1);
    check("t1_sel", start_sel[0], 0);
    check("t1_pending", pending, 0);
    step(BL + MG + 10);
    check("t1_no_repeat", n_starts, 1);

    // All four together served in index order with gaps
    do_reset();
    n0 = n_starts;
    press(4'b1111, PRESS);
    wait_starts(n0 + 4, 300);
    check("t2_sel0", start_sel[n0], 0);
    check("t2_sel1", start_sel[n0 + 1], 1);
    check("t2_sel2", start_sel[n0 + 2], 2);
    check("t2_sel3", start_sel[n0 + 3], 3);
    check("t2_gap1", gap_ok(n0 + 1), 1);
    check("t2_gap2", gap_ok(n0 + 2), 1);
    check("t2_gap3", gap_ok(n0 + 3), 1);
    step(BL + 5);

    // rr_last=1 with pending 1001 -> 3 before 0
    do_reset();
    n0 = n_starts;
    press(4'b0010, PRESS);
    wait_starts(n0 + 1, 30);
    check("t3_first", start_sel[n0], 1);
    press(4'b1001, PRESS);
    step(2);
    check("t3_pending", pending, 4'b1001);
    wait_starts(n0 + 3, 200);
    check("t3_sel3", start_sel[n0 + 1], 3);
    check("t3_sel0", start_sel[n0 + 2], 0);
    step(BL + 5);

    // Sequencer never goes busy -> ack timeout
    model_en = 1'b0;
    man_busy = 1'b0;
    do_reset();
    n0 = n_starts;
    press(4'b0100, PRESS);
    wait_starts(n0 + 1, 30);
    wait_n = start_cyc[n0] + AT - cyc;
    step(wait_n);
    check("t4_fault_early", ack_fault, 0);
    step(1);
    check("t4_fault", ack_fault, 1);
    check("t4_pending", pending, 0);
    check("t4_sel", xing.xing_sel, 2);

    // Still grants after a fault; reset in RUN clears everything
    model_en = 1'b1;
    n0 = n_starts;
    press(4'b1000, PRESS);
    wait_starts(n0 + 1, 30);
    check("t4b_sel", start_sel[n0], 3);
    step(4);
    press(4'b0001, PRESS);
    step(2);
    check("t4b_pending", pending, 4'b0001);
    check("t4b_sticky", ack_fault, 1);
    reset = 1'b1;
    step(1);
    check("rrun_start", xing.xing_start, 0);
    check("rrun_sel", xing.xing_sel, 0);
    check("rrun_pending", pending, 0);
    check("rrun_fault", ack_fault, 0);
    reset = 1'b0;
    step(BL + 5);

    // Re-press during RUN is latched and re-served
    n0 = n_starts;
    press(4'b0100, PRESS);
    wait_starts(n0 + 1, 30);
    check("t5_sel", start_sel[n0], 2);
    step(3);
    press(4'b0100, PRESS);
    step(2);
    check("t5_pending", pending, 4'b0100);
    wait_starts(n0 + 2, 100);
    check("t5_resel", start_sel[n0 + 1], 2);
    check("t5_gap", gap_ok(n0 + 1), 1);
    step(1);
    check("t5_cleared", pending, 0);
    step(BL + MG + 5);

`ifdef DEBOUNCE_EN
    // Short glitch rejected, DC+2 press accepted
    n0 = n_starts;
    press(4'b0010, 2);
    step(12);
    check("t6_glitch_pend", pending, 0);
    check("t6_glitch_starts", n_starts, n0);
    press(4'b0010, DC + 2);
    wait_starts(n0 + 1, 30);
    check("t6_press_sel", start_sel[n0], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
